apb_decoder_master: RTL and testbench
=====================================

Name: apb_decoder_master

Overview:
- APB initiator that drives the Hamming decoder peripheral from fabric logic with no CPU involvement.
- Accepts a 40-bit codeword over a valid/ready request port.
- Runs three APB transfers against the peripheral:
  - write IN1 (codeword[31:0])
  - write IN2 ({24'b0, codeword[39:32]})
  - read OUT
- Returns the 16-bit decoded word, plus an error flag, on a valid/ready response port.

Parameters:
- BASE_ADDR, 32'h0000_0000, peripheral base address; IN1/IN2/OUT sit at BASE_ADDR+0/+4/+8.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before abort. Used only with the optional feature; legal range 1..255.

Ports:
- PCLK input 1: clock; all logic on the rising edge.
- PRESET input 1: reset, synchronous, active-high.
- req_valid input 1: a request is present.
- req_ready output 1: the block can accept a request.
- req_codeword input 40: codeword, captured when req_valid & req_ready.
- rsp_valid output 1: a response is held.
- rsp_ready input 1: the consumer accepts the response.
- rsp_data output 16: decoded data, PRDATA[15:0] of the OUT read.
- rsp_err output 1: the transaction aborted (PSLVERR, or timeout).
- PADDR output 32: APB address.
- PWDATA output 32: APB write data.
- PSEL output 1: APB select.
- PENABLE output 1: APB enable.
- PWRITE output 1: APB direction (1 = write).
- PRDATA input 32: APB read data.
- PREADY input 1: APB ready.
- PSLVERR input 1: APB error.

Behaviour:
- All outputs are registered.
- On PRESET=1 at an edge, every output and internal register goes to 0 at that edge, except req_ready, which is 1 after reset.
- Reset mid-transaction drops the transaction silently: no response is produced and the APB bus returns to idle.
- States: IDLE, SETUP, ACCESS, RESP. A 2-bit step register selects 0=wr IN1, 1=wr IN2, 2=rd OUT.
- IDLE:
  - req_ready=1.
  - On req_valid: latch the codeword, step=0, go to SETUP, req_ready=0.
- SETUP:
  - PSEL=1, PENABLE=0.
  - PADDR = BASE_ADDR + 4*step.
  - PWRITE=1 for steps 0 and 1, 0 for step 2.
  - PWDATA = codeword[31:0] for step 0; {24'b0, codeword[39:32]} for step 1; 0 for step 2.
  - Exactly one cycle, then ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; address, data and direction held stable.
  - PREADY=0: stay in ACCESS.
  - PREADY=1 and PSLVERR=1: rsp_err=1, rsp_data=0, go to RESP. Remaining steps are skipped.
  - PREADY=1, PSLVERR=0, step<2: step+1, go to SETUP (back-to-back transfer; PSEL stays 1).
  - PREADY=1, PSLVERR=0, step=2: rsp_data=PRDATA[15:0], rsp_err=0, go to RESP. PRDATA[31:16] is ignored.
  - PSLVERR is sampled only when PREADY=1.
- RESP:
  - PSEL=0, PENABLE=0.
  - rsp_valid=1; rsp_data and rsp_err held stable until rsp_valid & rsp_ready.
  - On the handshake: rsp_valid=0, go to IDLE, req_ready=1 on the following cycle. There is no IDLE bypass, so the minimum request spacing is 8 cycles.
- Latency with a zero-wait slave:
  - Acceptance edge = cycle 0.
  - SETUP in cycles 1, 3, 5; ACCESS in cycles 2, 4, 6.
  - rsp_valid high from cycle 7.
  - Each PREADY-low cycle adds one cycle.
- rsp_ready while not in RESP has no effect.
- req_valid while req_ready=0 is ignored; the request must be held until accepted.
- When PSEL=0, PADDR, PWDATA and PWRITE retain their last values.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- With the macro:
  - An 8-bit wait counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
  - If it reaches TIMEOUT_CYCLES while PREADY=0, the block goes to RESP at that edge with rsp_err=1 and rsp_data=0. PSEL and PENABLE drop in the same cycle.
  - Output port timeout_flag (1 bit) is added: 1 with rsp_err when the abort was a timeout, 0 otherwise, cleared on the RESP handshake.
- Without the macro:
  - No counter and no timeout_flag port.
  - ACCESS waits indefinitely for PREADY.

Test Plan:
- Reset check: hold PRESET=1 for 3 cycles with req_valid=1 -> all APB outputs 0, rsp_valid=0, req_ready=1 on the first cycle after release.
- Zero-wait transaction: req_codeword=40'hA5_1234_5678, slave model returns PRDATA=32'hFFFF_BEEF on the OUT read:
  - Writes seen: 32'h1234_5678 @BASE+0, 32'h0000_00A5 @BASE+4.
  - Read @BASE+8.
  - rsp_valid at cycle 7 with rsp_data=16'hBEEF, rsp_err=0.
- Wait states: PREADY=0 for 3 cycles on each transfer -> PADDR, PWDATA and PWRITE stable through each ACCESS; rsp_valid at cycle 16; data correct.
- Slave error: PSLVERR=1 on the step-1 write -> no OUT read issued; rsp_err=1, rsp_data=0; next request proceeds normally.
- Back-pressure and mid-operation reset:
  - rsp_ready=0 for 5 cycles -> rsp outputs stable and req_ready=0 throughout.
  - PRESET pulsed during the step-1 ACCESS -> bus idle next cycle, no response produced.
- APB_MASTER_TIMEOUT_EN with TIMEOUT_CYCLES=4, PREADY held 0 -> abort after 4 wait cycles with rsp_err=1, timeout_flag=1.

Source files
------------

// File: rtl/apb_decoder_master.sv
// APB initiator that pushes one 40-bit codeword into the Hamming decoder peripheral and returns the decoded word.
// Optional build macro APB_MASTER_TIMEOUT_EN adds an ACCESS wait-state timeout and the timeout_flag output.
module apb_decoder_master #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [39:0] req_codeword,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
`ifdef APB_MASTER_TIMEOUT_EN
  output logic        timeout_flag,
`endif
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a transfer happens on the rising edge where valid & ready are both 1;
  // valid must stay asserted with stable payload until that edge.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t      state_q;
  logic [1:0]  step_q;
  logic [7:0]  cw_hi_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [15:0] rsp_data_q;
  logic        rsp_err_q;
  logic [31:0] paddr_q;
  logic [31:0] pwdata_q;
  logic        psel_q;
  logic        penable_q;
  logic        pwrite_q;

  logic [1:0]  step_d;
  logic [31:0] paddr_d;
  logic [31:0] pwdata_d;
  logic        unused_prdata_hi;

  assign unused_prdata_hi = ^PRDATA[31:16];

  // Address/data of the transfer that follows the current step.
  assign step_d   = step_q + 2'd1;
  assign paddr_d  = BASE_ADDR + {28'd0, step_d, 2'b00};
  assign pwdata_d = (step_q == 2'd0) ? {24'd0, cw_hi_q} : 32'd0;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] wait_q;
  logic       timeout_q;
  assign timeout_flag = timeout_q;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      step_q      <= 2'd0;
      cw_hi_q     <= 8'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'd0;
      rsp_err_q   <= 1'b0;
      paddr_q     <= 32'd0;
      pwdata_q    <= 32'd0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_q      <= 8'd0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            cw_hi_q     <= req_codeword[39:32];
            step_q      <= 2'd0;
            req_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            paddr_q     <= BASE_ADDR;
            pwrite_q    <= 1'b1;
            pwdata_q    <= req_codeword[31:0];
            state_q     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
          wait_q    <= 8'd0;
`endif
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            if (PSLVERR) begin
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= 16'd0;
              rsp_valid_q <= 1'b1;
              psel_q      <= 1'b0;
              penable_q   <= 1'b0;
              state_q     <= ST_RESP;
            end else if (step_q != 2'd2) begin
              // Back-to-back: PSEL stays high, only PENABLE drops.
              step_q    <= step_d;
              penable_q <= 1'b0;
              paddr_q   <= paddr_d;
              pwrite_q  <= (step_q == 2'd0);
              pwdata_q  <= pwdata_d;
              state_q   <= ST_SETUP;
            end else begin
              rsp_err_q   <= 1'b0;
              rsp_data_q  <= PRDATA[15:0];
              rsp_valid_q <= 1'b1;
              psel_q      <= 1'b0;
              penable_q   <= 1'b0;
              state_q     <= ST_RESP;
            end
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (wait_q + 8'd1 == TO_LIMIT) begin
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= 16'd0;
            rsp_valid_q <= 1'b1;
            timeout_q   <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= ST_RESP;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
`endif
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_decoder_master.sv
// Directed bench for apb_decoder_master: reactive APB slave model, transfer log vs expected queue, per-scenario tasks.
module tb_apb_decoder_master;

  localparam logic [31:0] BASE = 32'h4000_1000;

  logic        PCLK;
  logic        PRESET;
  logic        req_valid;
  logic        req_ready;
  logic [39:0] req_codeword;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [1:0]  dbg_state;
`ifdef APB_MASTER_TIMEOUT_EN
  logic        timeout_flag;
`endif

  int checks = 0;
  int errors = 0;

  // Slave model configuration and transfer log
  int          wait_n   = 0;
  int          err_step = -1;
  int          xfer_idx = 0;
  int          wait_cnt = 0;
  int          stable_bad = 0;
  logic [31:0] rdata    = 32'h0;
  logic [64:0] snap;
  logic [64:0] exp_q[$];
  logic [64:0] act_q[$];

  apb_decoder_master #(
    .BASE_ADDR      (BASE),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .PCLK         (PCLK),
    .PRESET       (PRESET),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_codeword (req_codeword),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .PADDR        (PADDR),
    .PWDATA       (PWDATA),
    .PSEL         (PSEL),
    .PENABLE      (PENABLE),
    .PWRITE       (PWRITE),
    .PRDATA       (PRDATA),
    .PREADY       (PREADY),
    .PSLVERR      (PSLVERR),
`ifdef APB_MASTER_TIMEOUT_EN
    .timeout_flag (timeout_flag),
`endif
    .dbg_state_o  (dbg_state)
  );

  // Clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Slave: decides PREADY/PSLVERR for the coming edge, logs completed transfers.
  always @(negedge PCLK) begin
    if (PSEL && !PENABLE) begin
      snap     = {PWRITE, PADDR, PWDATA};
      wait_cnt = 0;
      PREADY   = 1'b0;
      PSLVERR  = 1'b0;
    end else if (PSEL && PENABLE) begin
      if ({PWRITE, PADDR, PWDATA} !== snap) stable_bad++;
      if (wait_cnt < wait_n) begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        wait_cnt++;
      end else begin
        PREADY  = 1'b1;
        PSLVERR = (xfer_idx == err_step);
        PRDATA  = PWRITE ? 32'hDEAD_DEAD : rdata;
        act_q.push_back({PWRITE, PADDR, PWDATA});
        xfer_idx++;
      end
    end else begin
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
    end
  end

  // Driver tasks
  task automatic send_req(input logic [39:0] cw);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_accept: req_ready=%b, required 1 within 50 cycles", req_ready);
    end
    xfer_idx     = 0;
    req_valid    = 1'b1;
    req_codeword = cw;
    @(posedge PCLK);
    @(negedge PCLK);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (!rsp_valid && cyc < 200) begin
      @(negedge PCLK);
      cyc++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    rsp_ready = 1'b0;
  endtask

  task automatic expect_full_txn(input logic [39:0] cw);
    exp_q.delete();
    act_q.delete();
    exp_q.push_back({1'b1, BASE,          cw[31:0]});
    exp_q.push_back({1'b1, BASE + 32'd4,  {24'd0, cw[39:32]}});
    exp_q.push_back({1'b0, BASE + 32'd8,  32'd0});
  endtask

  // Scenarios
  task automatic test_reset();
    PRESET    = 1'b1;
    req_valid = 1'b1;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== 67'd0) begin
      errors++;
      $display("FAIL reset_apb: sel=%b en=%b wr=%b addr=%h wdata=%h, required all 0", PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_data, req_ready} !== {1'b0, 1'b0, 16'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_rsp: rsp_valid=%b rsp_err=%b rsp_data=%h req_ready=%b, required 0 0 0000 1", rsp_valid, rsp_err, rsp_data, req_ready);
    end
    PRESET    = 1'b0;
    req_valid = 1'b0;
    @(negedge PCLK);
    checks++;
    if (req_ready !== 1'b1 || PSEL !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_release: req_ready=%b PSEL=%b state=%0d, required 1 0 0", req_ready, PSEL, dbg_state);
    end
  endtask

  task automatic test_zero_wait();
    int cyc;
    wait_n = 0; err_step = -1; rdata = 32'hFFFF_BEEF;
    expect_full_txn(40'hA5_1234_5678);
    send_req(40'hA5_1234_5678);
    wait_rsp(cyc);
    checks++;
    if (cyc !== 7) begin
      errors++;
      $display("FAIL zw_latency: rsp_valid at cycle %0d, required 7", cyc);
    end
    checks++;
    if (rsp_data !== 16'hBEEF || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL zw_rsp: data=%h err=%b req_ready=%b, required beef 0 0", rsp_data, rsp_err, req_ready);
    end
    finish_rsp();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL zw_handshake: rsp_valid=%b req_ready=%b, required 0 1", rsp_valid, req_ready);
    end
    checks++;
    if (act_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL zw_xfer_count: %0d transfers, required %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL zw_xfer%0d: {wr,addr,data}=%h, required %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_wait_states();
    int cyc;
    wait_n = 3; err_step = -1; rdata = 32'h1234_5A5A; stable_bad = 0;
    expect_full_txn(40'h3C_DEAD_0001);
    send_req(40'h3C_DEAD_0001);
    wait_rsp(cyc);
    checks++;
    if (cyc !== 16) begin
      errors++;
      $display("FAIL ws_latency: rsp_valid at cycle %0d, required 16", cyc);
    end
    checks++;
    if (rsp_data !== 16'h5A5A || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL ws_rsp: data=%h err=%b, required 5a5a 0", rsp_data, rsp_err);
    end
    checks++;
    if (stable_bad !== 0) begin
      errors++;
      $display("FAIL ws_stable: %0d ACCESS cycles changed addr/data/dir, required 0", stable_bad);
    end
    finish_rsp();
    checks++;
    if (act_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL ws_xfer_count: %0d transfers, required %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ws_xfer%0d: {wr,addr,data}=%h, required %h", i, act_q[i], exp_q[i]);
      end
    end
    wait_n = 0;
  endtask

  task automatic test_slave_error();
    int cyc;
    wait_n = 0; err_step = 1; rdata = 32'h0000_7777;
    expect_full_txn(40'h77_0BAD_F00D);
    void'(exp_q.pop_back());
    send_req(40'h77_0BAD_F00D);
    wait_rsp(cyc);
    checks++;
    if (cyc !== 5) begin
      errors++;
      $display("FAIL err_latency: rsp_valid at cycle %0d, required 5", cyc);
    end
    checks++;
    if (rsp_err !== 1'b1 || rsp_data !== 16'h0000) begin
      errors++;
      $display("FAIL err_rsp: err=%b data=%h, required 1 0000", rsp_err, rsp_data);
    end
    finish_rsp();
    checks++;
    if (act_q.size() !== 2) begin
      errors++;
      $display("FAIL err_no_read: %0d transfers, required 2", act_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL err_xfer%0d: {wr,addr,data}=%h, required %h", i, act_q[i], exp_q[i]);
      end
    end
    err_step = -1; rdata = 32'hABCD_00C3;
    send_req(40'h01_0000_FFFF);
    wait_rsp(cyc);
    checks++;
    if (cyc !== 7 || rsp_data !== 16'h00C3 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL err_recover: cycle=%0d data=%h err=%b, required 7 00c3 0", cyc, rsp_data, rsp_err);
    end
    finish_rsp();
  endtask

  task automatic test_backpressure();
    int cyc;
    wait_n = 0; err_step = -1; rdata = 32'h0000_1357;
    send_req(40'h5A_0F0F_F0F0);
    wait_rsp(cyc);
    req_valid = 1'b1;
    req_codeword = 40'hFF_FFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'h1357 || rsp_err !== 1'b0 || req_ready !== 1'b0 || PSEL !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b data=%h err=%b req_ready=%b psel=%b, required 1 1357 0 0 0", i, rsp_valid, rsp_data, rsp_err, req_ready, PSEL);
      end
      @(negedge PCLK);
    end
    req_valid = 1'b0;
    finish_rsp();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: rsp_valid=%b req_ready=%b, required 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    int seen;
    int cyc;
    wait_n = 2; err_step = -1; rdata = 32'h0000_2468;
    send_req(40'h11_2233_4455);
    n = 0;
    while (!(PSEL && PENABLE && PADDR == BASE + 32'd4) && n < 40) begin
      @(negedge PCLK);
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL mr_reach_step1: step-1 ACCESS not seen within 40 cycles");
    end
    PRESET = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
    checks++;
    if (PSEL !== 1'b0 || PENABLE !== 1'b0 || PADDR !== 32'd0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL mr_idle: psel=%b en=%b addr=%h rsp_valid=%b req_ready=%b, required 0 0 0 0 1", PSEL, PENABLE, PADDR, rsp_valid, req_ready);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge PCLK);
      if (rsp_valid || PSEL) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mr_no_rsp: %0d cycles with rsp_valid or PSEL after reset, required 0", seen);
    end
    wait_n = 0;
    send_req(40'h22_0000_0000);
    wait_rsp(cyc);
    checks++;
    if (cyc !== 7 || rsp_data !== 16'h2468 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL mr_recover: cycle=%0d data=%h err=%b, required 7 2468 0", cyc, rsp_data, rsp_err);
    end
    finish_rsp();
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    wait_n = 1000; err_step = -1;
    send_req(40'h99_8877_6655);
    wait_rsp(cyc);
    checks++;
    if (cyc !== 6) begin
      errors++;
      $display("FAIL to_latency: rsp_valid at cycle %0d, required 6", cyc);
    end
    checks++;
    if (rsp_err !== 1'b1 || timeout_flag !== 1'b1 || rsp_data !== 16'h0000 || PSEL !== 1'b0 || PENABLE !== 1'b0) begin
      errors++;
      $display("FAIL to_rsp: err=%b tflag=%b data=%h psel=%b en=%b, required 1 1 0000 0 0", rsp_err, timeout_flag, rsp_data, PSEL, PENABLE);
    end
    finish_rsp();
    checks++;
    if (timeout_flag !== 1'b0) begin
      errors++;
      $display("FAIL to_clear: timeout_flag=%b, required 0", timeout_flag);
    end
    wait_n = 0;
  endtask
`endif

  initial begin
    PRESET       = 1'b1;
    req_valid    = 1'b0;
    req_codeword = 40'd0;
    rsp_ready    = 1'b0;
    PRDATA       = 32'd0;
    PREADY       = 1'b0;
    PSLVERR      = 1'b0;
    snap         = 65'd0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_slave_error();
    test_backpressure();
    test_mid_reset();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
